// File: rtl/cache_axi_mem_ctrl_if.sv
// AXI4 master-side bus between the cache memory controller and the system interconnect.
// Carries the AW/W/B/AR/R channels as seen from either end.
interface cache_axi_mem_ctrl_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  logic [ADDR_SIZE-1:0]   awaddr;
  logic [7:0]             awlen;
  logic [2:0]             awsize;
  logic [1:0]             awburst;
  logic                   awvalid;
  logic                   awready;

  logic [DATA_SIZE-1:0]   wdata;
  logic [DATA_SIZE/8-1:0] wstrb;
  logic                   wlast;
  logic                   wvalid;
  logic                   wready;

  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;

  logic [ADDR_SIZE-1:0]   araddr;
  logic [7:0]             arlen;
  logic [2:0]             arsize;
  logic [1:0]             arburst;
  logic                   arvalid;
  logic                   arready;

  logic [DATA_SIZE-1:0]   rdata;
  logic [1:0]             rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/cache_axi_mem_ctrl.sv
// Cache memory-side controller: buffers one cache line and moves it as a single
// AXI4 INCR burst, either a dirty-victim write-back or a line load.
module cache_axi_mem_ctrl #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int WORDS     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         addr_valid_out,
  input  logic [ADDR_SIZE-1:0]         addr_out_m,
  input  logic                         rw_out,
  output logic                         ready_wb,
  input  logic                         valid_wb,
  input  logic [WORDS*DATA_SIZE-1:0]   data_out_m,
  output logic                         valid_ld,
  output logic [WORDS*DATA_SIZE-1:0]   data_in_m,
  input  logic                         ready_ld,
  output logic                         mem_err,
  cache_axi_mem_ctrl_if.master         axi
);

  localparam int LINE_W = WORDS * DATA_SIZE;
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int OFF_W  = $clog2(WORDS * DATA_SIZE / 8);
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [ADDR_SIZE-1:0] OFF_MASK  = ADDR_SIZE'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [3:0] {
    IDLE, WB_TAKE, AW, W, B, AR, R, LD, HOLD
  } state_t;

  state_t                  state;
  logic [BEAT_W-1:0]       beat;
  logic [BEAT_W-1:0]       beat_inc;
  logic [LINE_W-1:0]       line_reg;
  logic [ADDR_SIZE-1:0]    addr_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    wlast_reg;
  logic [DATA_SIZE-1:0]    wdata_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic [DATA_SIZE-1:0]    line_word [WORDS];

  assign beat_inc = beat + BEAT_W'(1);

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign line_word[gi] = line_reg[gi*DATA_SIZE +: DATA_SIZE];
  end

  // One address register serves both directions since only one burst is ever in flight.
  assign axi.awaddr  = addr_reg;
  assign axi.awlen   = 8'(WORDS - 1);
  assign axi.awsize  = 3'($clog2(DATA_SIZE / 8));
  assign axi.awburst = 2'b01;
  assign axi.awvalid = awvalid_reg;
  assign axi.wdata   = wdata_reg;
  assign axi.wstrb   = '1;
  assign axi.wlast   = wlast_reg;
  assign axi.wvalid  = wvalid_reg;
  assign axi.bready  = bready_reg;
  assign axi.araddr  = addr_reg;
  assign axi.arlen   = 8'(WORDS - 1);
  assign axi.arsize  = 3'($clog2(DATA_SIZE / 8));
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid_reg;
  assign axi.rready  = rready_reg;
  assign data_in_m   = line_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beat        <= '0;
      line_reg    <= '0;
      addr_reg    <= '0;
      ready_wb    <= 1'b0;
      valid_ld    <= 1'b0;
      mem_err     <= 1'b0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      wlast_reg   <= 1'b0;
      wdata_reg   <= '0;
      bready_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (addr_valid_out) begin
            addr_reg <= addr_out_m & ~OFF_MASK;
            if (rw_out) begin
              ready_wb <= 1'b1;
              state    <= WB_TAKE;
            end else begin
              arvalid_reg <= 1'b1;
              state       <= AR;
            end
          end
        end

        WB_TAKE: begin
          if (valid_wb && ready_wb) begin
            line_reg    <= data_out_m;
            ready_wb    <= 1'b0;
            awvalid_reg <= 1'b1;
            state       <= AW;
          end
        end

        AW: begin
          if (axi.awready) begin
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b1;
            wdata_reg   <= line_word[0];
            wlast_reg   <= (LAST_BEAT == '0);
            beat        <= '0;
            state       <= W;
          end
        end

        // wdata/wlast are preloaded for the following beat so they stay registered.
        W: begin
          if (axi.wready) begin
            if (beat == LAST_BEAT) begin
              wvalid_reg <= 1'b0;
              wlast_reg  <= 1'b0;
              beat       <= '0;
              bready_reg <= 1'b1;
              state      <= B;
            end else begin
              beat      <= beat_inc;
              wdata_reg <= line_word[beat_inc];
              wlast_reg <= (beat_inc == LAST_BEAT);
            end
          end
        end

        B: begin
          if (axi.bvalid) begin
            if (axi.bresp != 2'b00) mem_err <= 1'b1;
            bready_reg <= 1'b0;
            state      <= HOLD;
          end
        end

        AR: begin
          if (axi.arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            beat        <= '0;
            state       <= R;
          end
        end

        // Completion follows the beat count; a misplaced RLAST only flags an error.
        R: begin
          if (axi.rvalid) begin
            line_reg[32'(beat)*DATA_SIZE +: DATA_SIZE] <= axi.rdata;
            if ((axi.rresp != 2'b00) || (axi.rlast != (beat == LAST_BEAT)))
              mem_err <= 1'b1;
            if (beat == LAST_BEAT) begin
              beat       <= '0;
              rready_reg <= 1'b0;
              valid_ld   <= 1'b1;
              state      <= LD;
            end else begin
              beat <= beat_inc;
            end
          end
        end

        LD: begin
          if (ready_ld) begin
            valid_ld <= 1'b0;
            state    <= HOLD;
          end
        end

        // Gives the cache one cycle to retire its registered request.
        HOLD: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_axi_mem_ctrl.sv
// Directed bench for cache_axi_mem_ctrl: the initial block plays both the cache and
// the AXI slave, with hand-derived expected values checked by immediate assertions.
module tb_cache_axi_mem_ctrl;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int WORDS = 64;
  localparam int LW    = WORDS * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          addr_valid_out;
  logic [AW-1:0] addr_out_m;
  logic          rw_out;
  logic          ready_wb;
  logic          valid_wb;
  logic [LW-1:0] data_out_m;
  logic          valid_ld;
  logic [LW-1:0] data_in_m;
  logic          ready_ld;
  logic          mem_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_axi_mem_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) axi ();

  cache_axi_mem_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .WORDS(WORDS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .addr_valid_out (addr_valid_out),
    .addr_out_m     (addr_out_m),
    .rw_out         (rw_out),
    .ready_wb       (ready_wb),
    .valid_wb       (valid_wb),
    .data_out_m     (data_out_m),
    .valid_ld       (valid_ld),
    .data_in_m      (data_in_m),
    .ready_ld       (ready_ld),
    .mem_err        (mem_err),
    .axi            (axi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    int k;
    total++;
    assert (obs === exp) else begin
      k = 0;
      while (k < WORDS - 1 && obs[k*DW +: DW] === exp[k*DW +: DW]) k++;
      bad++;
      $error("FAIL %s: word %0d observed %h expected %h", tag, k, obs[k*DW +: DW], exp[k*DW +: DW]);
    end
  endtask

  function automatic logic [DW-1:0] word_val(input int mode, input int i);
    case (mode)
      0:       return 32'h1234_5678;
      1:       return 32'(i);
      2:       return ~32'(i);
      3:       return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      default: return {16'(i), 16'hBEEF};
    endcase
  endfunction

  function automatic logic [LW-1:0] make_line(input int mode);
    logic [LW-1:0] l;
    for (int i = 0; i < WORDS; i++) l[i*DW +: DW] = word_val(mode, i);
    return l;
  endfunction

  function automatic int stall(input int en, input int i, input int seed);
    return (en != 0) ? ((i * 7 + seed) % 6) : 0;
  endfunction

  task automatic clear_inputs();
    addr_valid_out = 1'b0; addr_out_m = '0; rw_out = 1'b0;
    valid_wb = 1'b0; data_out_m = '0; ready_ld = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
  endtask

  // raise=0: a load request is already pending behind a write-back sitting in HOLD.
  task automatic do_load(input logic [AW-1:0] addr, input bit raise, input int mode,
                         input int st, input int rlast_beat, input bit exp_err);
    logic [LW-1:0] expl;
    expl = make_line(mode);
    if (raise) begin
      addr_valid_out = 1'b1; addr_out_m = addr; rw_out = 1'b0;
      tick();
    end else begin
      check("ar_held_off_hold", axi.arvalid, 1'b0);
      tick();
      check("ar_held_off_idle", axi.arvalid, 1'b0);
      tick();
    end
    check("arvalid_latency", axi.arvalid, 1'b1);
    check("araddr", axi.araddr, addr & ~32'hFF);
    check("ar_attr", {axi.arlen, axi.arsize, axi.arburst}, {8'd63, 3'd2, 2'b01});
    for (int s = 0; s < stall(st, 0, 3); s++) begin
      tick();
      check("arvalid_stall", axi.arvalid, 1'b1);
    end
    axi.arready = 1'b1; tick(); axi.arready = 1'b0;
    check("ar_accepted", {axi.arvalid, axi.rready}, 2'b01);
    for (int i = 0; i < WORDS; i++) begin
      for (int s = 0; s < stall(st, i, 1); s++) tick();
      axi.rvalid = 1'b1; axi.rdata = word_val(mode, i);
      axi.rlast = (i == rlast_beat); axi.rresp = 2'b00;
      check("r_beat_ready", {axi.rready, valid_ld}, 2'b10);
      tick();
      axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
    end
    check("valid_ld_latency", {valid_ld, axi.rready}, 2'b10);
    check_line("load_data", data_in_m, expl);
    check("load_mem_err", mem_err, exp_err);
    for (int s = 0; s < stall(st, 4, 2); s++) begin
      tick();
      check("valid_ld_stall", valid_ld, 1'b1);
    end
    ready_ld = 1'b1; tick(); ready_ld = 1'b0; addr_valid_out = 1'b0;
    check("ld_accepted", valid_ld, 1'b0);
    tick(); tick();
    check("load_idle", {axi.arvalid, ready_wb, axi.rready, axi.awvalid}, 4'b0000);
  endtask

  task automatic do_wb(input logic [AW-1:0] addr, input int mode, input int st,
                       input logic [1:0] bresp, input bit exp_err, input bit chain,
                       input logic [AW-1:0] load_addr, input int abort_beat);
    logic [LW-1:0] expl;
    expl = make_line(mode);
    addr_valid_out = 1'b1; addr_out_m = addr; rw_out = 1'b1;
    tick();
    check("ready_wb", ready_wb, 1'b1);
    for (int s = 0; s < stall(st, 0, 4); s++) begin
      tick();
      check("ready_wb_stall", {ready_wb, axi.awvalid}, 2'b10);
    end
    valid_wb = 1'b1; data_out_m = expl;
    tick();
    valid_wb = 1'b0; data_out_m = '0; addr_valid_out = 1'b0;
    check("awvalid_latency", {ready_wb, axi.awvalid, axi.wvalid}, 3'b010);
    check("awaddr", axi.awaddr, addr & ~32'hFF);
    check("aw_attr", {axi.awlen, axi.awsize, axi.awburst, axi.wstrb}, {8'd63, 3'd2, 2'b01, 4'hF});
    for (int s = 0; s < stall(st, 1, 0); s++) begin
      tick();
      check("w_before_aw", {axi.awvalid, axi.wvalid}, 2'b10);
    end
    axi.awready = 1'b1; tick(); axi.awready = 1'b0;
    if (chain) begin
      addr_valid_out = 1'b1; addr_out_m = load_addr; rw_out = 1'b0;
    end
    for (int i = 0; i < WORDS; i++) begin
      if (i == abort_beat) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              {axi.awvalid, axi.wvalid, axi.wlast, axi.bready, axi.arvalid, axi.rready,
               ready_wb, valid_ld, mem_err}, 9'd0);
        check_line("rst_async_line", data_in_m, '0);
        clear_inputs();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      for (int s = 0; s < stall(st, i, 5); s++) tick();
      check("w_beat", {axi.wvalid, axi.wlast, axi.arvalid, axi.wdata},
            {1'b1, (i == WORDS - 1), 1'b0, word_val(mode, i)});
      axi.wready = 1'b1; tick(); axi.wready = 1'b0;
    end
    check("b_wait", {axi.wvalid, axi.bready, axi.arvalid}, 3'b010);
    for (int s = 0; s < stall(st, 2, 1); s++) begin
      tick();
      check("bready_stall", {axi.bready, axi.arvalid}, 2'b10);
    end
    axi.bvalid = 1'b1; axi.bresp = bresp;
    tick();
    axi.bvalid = 1'b0; axi.bresp = 2'b00;
    check("b_accepted", {axi.bready, mem_err}, {1'b0, exp_err});
    if (!chain) begin
      tick();
      check("wb_idle", {ready_wb, axi.awvalid, axi.arvalid, axi.wvalid}, 4'b0000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick(); tick();
    check("reset_outputs",
          {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, ready_wb, valid_ld, mem_err},
          8'd0);
    check_line("reset_line", data_in_m, '0);
    rst_n = 1'b1;
    tick();

    // Plain load, then plain write-back, neither stalled.
    do_load(32'h0000_1234, 1'b1, 0, 0, 63, 1'b0);
    do_wb(32'h0000_ABCD, 1, 0, 2'b00, 1'b0, 1'b0, '0, -1);

    // Back-pressure on every channel.
    do_load(32'h0005_5A7C, 1'b1, 3, 1, 63, 1'b0);
    do_wb(32'h0001_2345, 2, 1, 2'b00, 1'b0, 1'b0, '0, -1);

    // Write-back with a load request queued behind it.
    do_wb(32'h0000_3F10, 4, 1, 2'b00, 1'b0, 1'b1, 32'h0000_7788, -1);
    do_load(32'h0000_7788, 1'b0, 1, 1, 63, 1'b0);

    // RLAST on beat 62: error flagged, line still delivered, flag sticky afterwards.
    do_load(32'h00C0_FFEE, 1'b1, 2, 0, 62, 1'b1);
    do_load(32'h0000_0100, 1'b1, 0, 1, 63, 1'b1);

    // Reset during W beat 20 clears the sticky error; then a SLVERR write response.
    do_wb(32'h0000_ABCD, 1, 0, 2'b00, 1'b0, 1'b0, '0, 20);
    check("post_reset_idle", {axi.awvalid, axi.wvalid, axi.arvalid, ready_wb, mem_err}, 5'd0);
    do_wb(32'h0000_4400, 3, 1, 2'b10, 1'b1, 1'b0, '0, -1);
    do_load(32'h0000_5555, 1'b1, 4, 1, 63, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_axi_mem_ctrl.md
Name: cache_axi_mem_ctrl

Overview:
Sequences the cache's memory-side interface onto an AXI4 master port. It accepts one block request at a time from cache_top: either a write-back of a dirty victim or a line load. It buffers the full line and issues a single INCR burst. It sits between cache_top and the system AXI interconnect.

Parameters:
ADDR_SIZE, 32, address width (cache and AXI)
DATA_SIZE, 32, word width and AXI data width
WORDS, 64, words per cache line; burst length is WORDS beats (WORDS ≤ 256, power of 2)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
addr_valid_out  in  1  cache block request pending
addr_out_m  in  ADDR_SIZE  request address, stable while addr_valid_out=1
rw_out  in  1  1=write-back, 0=load
ready_wb  out  1  controller ready to take write-back line
valid_wb  in  1  cache presents write-back line
data_out_m  in  WORDS*DATA_SIZE  write-back line, word 0 in LSBs
valid_ld  out  1  loaded line valid
data_in_m  out  WORDS*DATA_SIZE  loaded line, word 0 in LSBs
ready_ld  in  1  cache accepts loaded line
mem_err  out  1  sticky: bad BRESP/RRESP or RLAST mismatch
awaddr/araddr  out  ADDR_SIZE  line-aligned burst address
awlen/arlen  out  8  constant WORDS-1
awsize/arsize, awburst/arburst  out  3, 2  constants log2(DATA_SIZE/8), INCR (2'b01); wstrb tied all-ones
awvalid, awready  out, in  1  AW handshake
wdata  out  DATA_SIZE  write beat
wlast, wvalid, wready  out, out, in  1  W channel
bresp, bvalid, bready  in, in, out  2, 1, 1  B channel
arvalid, arready  out, in  1  AR handshake
rdata, rresp  in  DATA_SIZE, 2  read beat
rlast, rvalid, rready  in, in, out  1  R channel

Behaviour:
- Reset (async, any state): state=IDLE, beat counter=0, line buffer=0, mem_err=0, all valid/ready outputs=0, data_in_m=0. Any in-flight AXI burst is abandoned.
- All outputs are registered. Aligned address = addr_out_m with the low log2(WORDS*DATA_SIZE/8) bits cleared (8 bits at defaults). It is latched in IDLE.
- FSM: IDLE, WB_TAKE, AW, W, B, AR, R, LD, HOLD.
- IDLE: if addr_valid_out=1, latch address. Next state is WB_TAKE when rw_out=1, otherwise AR.
- WB_TAKE: ready_wb=1. On valid_wb&ready_wb, capture data_out_m into the buffer, drop ready_wb, go to AW. The cache treats this handshake as write-back completion and may drop addr_valid_out.
- AW: awvalid=1 until awready, then W. wvalid is never asserted before AW is accepted.
- W: wvalid=1, wdata=buffer[beat]. The beat counter increments on wready. wlast=1 when beat=WORDS-1. When the last beat is accepted, go to B with counter reset to 0.
- B: bready=1. On bvalid: set mem_err if bresp≠2'b00, then go to HOLD.
- AR: arvalid=1 until arready, then R.
- R: rready=1. Each rvalid&rready writes rdata into buffer[beat] and increments beat.
  - mem_err is set if rresp≠00, or if rlast disagrees with (beat=WORDS-1).
  - Completion is on the beat counter only. After beat WORDS-1 is accepted, go to LD; valid_ld rises the next cycle.
- LD: valid_ld=1 with data_in_m=buffer, held until ready_ld. On the handshake, drop valid_ld and go to HOLD.
- HOLD: exactly one cycle with addr_valid_out ignored, so the cache's registered request can deassert. Then IDLE.
- Only one transaction is in flight. A request arriving while busy waits; the cache holds addr_valid_out.
- Minimum latency:
  - Load: addr_valid_out → arvalid is 1 cycle. Last R beat → valid_ld is 1 cycle.
  - Write-back: valid_wb handshake → awvalid is 1 cycle.
- Errors do not abort a transfer: data is delivered as received. mem_err clears only on reset.

Test Plan:
- Load, no stalls: request addr 0x00001234, rw_out=0. Expect araddr=0x00001200, arlen=63, arvalid 1 cycle after request. Slave returns 64 beats of 0x12345678 with rlast on beat 63. Expect valid_ld 1 cycle after the last beat with all 64 words =0x12345678, held until ready_ld, mem_err=0.
- Write-back: rw_out=1, addr 0x0000ABCD, word i = i. Expect ready_wb until valid_wb; then awaddr=0x0000AB00, 64 W beats wdata=0..63, wlast only on beat 63. bvalid/OKAY returns to IDLE through HOLD.
- Back-pressure: random awready/wready/arready/rvalid/ready_ld stalls of 0-5 cycles. Expect identical data and no dropped or duplicated beats; valids held stable while stalled.
- Write-back then load: the cache drops addr_valid_out after the wb handshake and raises a load request. Expect no AR before the B response is accepted; the load completes correctly.
- Errors: bresp=2'b10 on a write, or rlast on beat 62. Expect mem_err=1 and sticky, with the transfer still completing (valid_ld after beat 63).
- Reset mid-burst: assert rst_n=0 during W beat 20. Expect all valids=0 immediately (asynchronously), IDLE, mem_err=0; the next request runs normally.
